dmem_arbiter: RTL

Two-requester arbiter and sequencer for the single-port data memory (100 × 32-bit, asynchronous read, write on rising `clk`). It shares the one memory port between requester 0 (CPU load/store path) and requester 1 (debug/loader port). Arbitration is round-robin with bounded bursts. The block also range-checks addresses and returns registered read data with a one-cycle valid pulse.

---
 rtl/dmem_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin, burst-bounded arbiter that shares one single-port
// data memory between a CPU load/store path (m0) and a debug/loader port (m1).
// Grants are combinational; read data, read-valid and range errors are
// registered and returned one cycle after the grant.
module dmem_arbiter #(
  parameter int Data_Width   = 32,
  parameter int Memory_Depth = 100,
  parameter int Max_Burst    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [Data_Width-1:0] m0_addr,
  input  logic [Data_Width-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [Data_Width-1:0] m0_rdata,
  output logic                  m0_err,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [Data_Width-1:0] m1_addr,
  input  logic [Data_Width-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [Data_Width-1:0] m1_rdata,
  output logic                  m1_err,
  output logic [Data_Width-1:0] mem_addr,
  output logic [Data_Width-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [Data_Width-1:0] mem_rdata
);

  localparam int                  CW    = $clog2(Max_Burst + 1);
  localparam logic [CW-1:0]       MAXC  = CW'(Max_Burst);
  localparam logic [Data_Width-1:0] DEPTH = Data_Width'(Memory_Depth);

  // owner: 0 = m0, 1 = m1. Reset to 1 so the first tie goes to m0.
  logic          owner;
  logic          active;
  logic [CW-1:0] cnt;

  logic                  g0, g1, any_gnt;
  logic                  sel_we;
  logic [Data_Width-1:0] sel_addr, sel_wdata;
  logic                  in_range;

  // Grant selection; everything is held off while reset is asserted.
  always_comb begin
    g0 = 1'b0;
    g1 = 1'b0;
    if (reset) begin
      if (m0_req && m1_req) begin
        if (active && (cnt < MAXC)) begin
          g0 = ~owner;
          g1 = owner;
        end else begin
          g0 = owner;
          g1 = ~owner;
        end
      end else begin
        g0 = m0_req;
        g1 = m1_req;
      end
    end
  end

  assign any_gnt = g0 | g1;
  assign m0_gnt  = g0;
  assign m1_gnt  = g1;

  // Memory port mux: granted requester's fields, zero when idle.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (g1) begin
      sel_we    = m1_we;
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
    end else if (g0) begin
      sel_we    = m0_we;
      sel_addr  = m0_addr;
      sel_wdata = m0_wdata;
    end
  end

  // Full-width unsigned compare so huge addresses never alias into range.
  assign in_range  = sel_addr < DEPTH;
  assign mem_addr  = sel_addr;
  assign mem_wdata = sel_wdata;
  assign mem_we    = any_gnt & sel_we & in_range;

  // Burst tracking: cnt saturates at Max_Burst while the owner keeps the port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner  <= 1'b1;
      active <= 1'b0;
      cnt    <= '0;
    end else if (any_gnt) begin
      if ((g1 == owner) && active) begin
        if (cnt != MAXC) cnt <= cnt + CW'(1);
      end else begin
        cnt <= CW'(1);
      end
      owner  <= g1;
      active <= 1'b1;
    end else begin
      active <= 1'b0;
      cnt    <= '0;
    end
  end

  // Registered responses; rdata holds until that requester's next read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m0_rvalid <= 1'b0;
      m0_err    <= 1'b0;
      m0_rdata  <= '0;
      m1_rvalid <= 1'b0;
      m1_err    <= 1'b0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= g0 & ~sel_we;
      m0_err    <= g0 & ~in_range;
      m1_rvalid <= g1 & ~sel_we;
      m1_err    <= g1 & ~in_range;
      if (g0 && !sel_we) m0_rdata <= in_range ? mem_rdata : '0;
      if (g1 && !sel_we) m1_rdata <= in_range ? mem_rdata : '0;
    end
  end

endmodule
